// File: rtl/ddram_wr_buffer.sv
// Core-side write FIFO and single read slot feeding the toggle req/ack DDRAM port stage.
// A captured read is held back until every write queued ahead of it has been acknowledged.
module ddram_wr_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic [27:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic        wr_strobe,
    output logic        wr_full,
    output logic        wr_overflow,
    input  logic [27:0] rd_addr,
    input  logic        rd_strobe,
    output logic        rd_busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [27:0] wraddr,
    output logic [15:0] din,
    output logic        we_req,
    input  logic        we_ack,
    output logic [27:0] rdaddr,
    input  logic [7:0]  dout,
    output logic        rd_req,
    input  logic        rd_ack
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

    logic [43:0]           mem_q [DEPTH];
    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d, drain_cnt_q, drain_cnt_d;
    logic                  wr_full_q, wr_full_d, wr_overflow_q, wr_overflow_d;
    logic                  rd_busy_q, rd_busy_d, rd_valid_q, rd_valid_d;
    logic [27:0]           rd_addr_lat_q, rd_addr_lat_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic [27:0]           wraddr_q, wraddr_d, rdaddr_q, rdaddr_d;
    logic [15:0]           din_q, din_d;
    logic                  we_req_q, we_req_d, rd_req_q, rd_req_d;
    logic                  push, pop, rd_take;
    logic [43:0]           head;

    always_comb begin
        push    = wr_strobe && !wr_full_q;
        pop     = (state_q == WR_WAIT) && (we_ack == we_req_q);
        rd_take = rd_strobe && !rd_busy_q;
        head    = mem_q[rd_ptr_q];

        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
        wr_full_d     = (count_d == CNT_FULL);
        wr_overflow_d = wr_overflow_q || (wr_strobe && wr_full_q);

        // A same-cycle write is already in count_d, so it drains ahead of the read.
        rd_busy_d     = rd_busy_q;
        rd_addr_lat_d = rd_addr_lat_q;
        drain_cnt_d   = drain_cnt_q;
        if (rd_take) begin
            rd_busy_d     = 1'b1;
            rd_addr_lat_d = rd_addr;
            drain_cnt_d   = count_d;
        end else if (pop && drain_cnt_q != '0) begin
            drain_cnt_d = drain_cnt_q - CNT_ONE;
        end

        state_d    = state_q;
        wraddr_d   = wraddr_q;
        din_d      = din_q;
        rdaddr_d   = rdaddr_q;
        we_req_d   = we_req_q;
        rd_req_d   = rd_req_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_busy_q && drain_cnt_q == '0) begin
                    rdaddr_d = rd_addr_lat_q;
                    rd_req_d = ~rd_req_q;
                    state_d  = RD_WAIT;
                end else if (count_q != '0) begin
                    wraddr_d = head[43:16];
                    din_d    = head[15:0];
                    we_req_d = ~we_req_q;
                    state_d  = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (pop) state_d = IDLE;
            end
            RD_WAIT: begin
                if (rd_ack == rd_req_q) begin
                    rd_data_d  = dout;
                    rd_valid_d = 1'b1;
                    rd_busy_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
    end

    // Requests are re-aligned to the acks so nothing is left outstanding after reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            drain_cnt_q   <= '0;
            wr_full_q     <= 1'b0;
            wr_overflow_q <= 1'b0;
            rd_busy_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_addr_lat_q <= '0;
            rd_data_q     <= '0;
            wraddr_q      <= '0;
            din_q         <= '0;
            rdaddr_q      <= '0;
            we_req_q      <= we_ack;
            rd_req_q      <= rd_ack;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            drain_cnt_q   <= drain_cnt_d;
            wr_full_q     <= wr_full_d;
            wr_overflow_q <= wr_overflow_d;
            rd_busy_q     <= rd_busy_d;
            rd_valid_q    <= rd_valid_d;
            rd_addr_lat_q <= rd_addr_lat_d;
            rd_data_q     <= rd_data_d;
            wraddr_q      <= wraddr_d;
            din_q         <= din_d;
            rdaddr_q      <= rdaddr_d;
            we_req_q      <= we_req_d;
            rd_req_q      <= rd_req_d;
        end
    end

    assign wr_full     = wr_full_q;
    assign wr_overflow = wr_overflow_q;
    assign rd_busy     = rd_busy_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign wraddr      = wraddr_q;
    assign din         = din_q;
    assign we_req      = we_req_q;
    assign rdaddr      = rdaddr_q;
    assign rd_req      = rd_req_q;
endmodule

// File: tb/tb_ddram_wr_buffer.sv
// Directed bench for ddram_wr_buffer with a toggle-handshake DDRAM responder and byte memory model.
module tb_ddram_wr_buffer;
    logic        DDRAM_CLK = 1'b0;
    logic        reset = 1'b1;
    logic [27:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_strobe = 1'b0;
    logic        wr_full, wr_overflow;
    logic [27:0] rd_addr = '0;
    logic        rd_strobe = 1'b0;
    logic        rd_busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [27:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack = 1'b0;
    logic [27:0] rdaddr;
    logic [7:0]  dout = '0;
    logic        rd_req;
    logic        rd_ack = 1'b0;

    always #5 DDRAM_CLK = ~DDRAM_CLK;

    ddram_wr_buffer #(.DEPTH_LOG2(4)) dut (
        .DDRAM_CLK(DDRAM_CLK), .reset(reset),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
        .wr_full(wr_full), .wr_overflow(wr_overflow),
        .rd_addr(rd_addr), .rd_strobe(rd_strobe), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wraddr(wraddr), .din(din), .we_req(we_req), .we_ack(we_ack),
        .rdaddr(rdaddr), .dout(dout), .rd_req(rd_req), .rd_ack(rd_ack)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Downstream port: completes an op by copying req into ack after a delay.
    int wr_delay = 2;
    int rd_delay = 2;
    bit wr_stall = 1'b0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_ack_total = 0;
    logic [7:0] mem [logic [27:0]];

    always @(posedge DDRAM_CLK) begin
        if (we_req !== we_ack) begin
            if (!wr_stall) begin
                if (wr_cnt >= wr_delay) begin
                    mem[{wraddr[27:1], 1'b0}] = din[7:0];
                    mem[{wraddr[27:1], 1'b1}] = din[15:8];
                    we_ack       <= we_req;
                    wr_ack_total <= wr_ack_total + 1;
                    wr_cnt       <= 0;
                end else begin
                    wr_cnt <= wr_cnt + 1;
                end
            end
        end else begin
            wr_cnt <= 0;
        end
        if (rd_req !== rd_ack) begin
            if (rd_cnt >= rd_delay) begin
                dout   <= mem.exists(rdaddr) ? mem[rdaddr] : 8'h00;
                rd_ack <= rd_req;
                rd_cnt <= 0;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end else begin
            rd_cnt <= 0;
        end
    end

    int wr_issue_cnt = 0;
    int rd_issue_cnt = 0;
    int rd_issue_wacks = 0;
    int rd_issue_wissue = 0;
    logic prev_we = 1'b0;
    logic prev_rd = 1'b0;
    logic [27:0] q_addr [$];
    logic [15:0] q_data [$];

    always @(negedge DDRAM_CLK) begin
        if (!reset) begin
            if (we_req !== prev_we) begin
                wr_issue_cnt = wr_issue_cnt + 1;
                q_addr.push_back(wraddr);
                q_data.push_back(din);
            end
            if (rd_req !== prev_rd) begin
                rd_issue_cnt    = rd_issue_cnt + 1;
                rd_issue_wacks  = wr_ack_total;
                rd_issue_wissue = wr_issue_cnt;
            end
        end
        prev_we = we_req;
        prev_rd = rd_req;
    end

    task automatic tick();
        @(posedge DDRAM_CLK);
        #3;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic push_wr(input logic [27:0] a, input logic [15:0] d);
        wr_addr   = a;
        wr_data   = d;
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic wait_acks(input int target, input int limit);
        int n = 0;
        while (wr_ack_total < target && n < limit) begin
            tick();
            n++;
        end
        repeat (2) tick();
        tests_run++;
        if (wr_ack_total !== target) begin
            tests_failed++;
            $display("FAIL ack_wait: got %0d acks, expected %0d", wr_ack_total, target);
        end
    endtask

    task automatic test_reset();
        wr_stall = 1'b0;
        do_reset(3);
        tests_run++;
        if ({wr_full, wr_overflow, rd_busy, rd_valid} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000", {wr_full, wr_overflow, rd_busy, rd_valid});
        end
        tests_run++;
        if (rd_data !== 8'h00 || wraddr !== 28'h0 || din !== 16'h0 || rdaddr !== 28'h0) begin
            tests_failed++;
            $display("FAIL reset_regs: got rd_data=%h wraddr=%h din=%h rdaddr=%h, expected all 0", rd_data, wraddr, din, rdaddr);
        end
        tests_run++;
        if (we_req !== we_ack || rd_req !== rd_ack) begin
            tests_failed++;
            $display("FAIL reset_reqs: got we_req=%b rd_req=%b, expected %b %b", we_req, rd_req, we_ack, rd_ack);
        end
    endtask

    task automatic test_back_to_back();
        int base_q, base_ack;
        do_reset(3);
        wr_delay = 20;
        base_q   = q_addr.size();
        base_ack = wr_ack_total;
        for (int i = 0; i < 16; i++) push_wr(28'h0010000 + 28'(2 * i), 16'hA000 + 16'(i * 257));
        tests_run++;
        if (wr_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_full: got wr_full=%b, expected 1", wr_full);
        end
        wait_acks(base_ack + 16, 1000);
        tests_run++;
        if (q_addr.size() - base_q !== 16) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d we_req toggles, expected 16", q_addr.size() - base_q);
        end
        for (int i = 0; i < 16 && base_q + i < q_addr.size(); i++) begin
            tests_run++;
            if (q_addr[base_q + i] !== 28'h0010000 + 28'(2 * i) || q_data[base_q + i] !== 16'hA000 + 16'(i * 257)) begin
                tests_failed++;
                $display("FAIL b2b_order[%0d]: got %h/%h, expected %h/%h", i, q_addr[base_q + i], q_data[base_q + i],
                         28'h0010000 + 28'(2 * i), 16'hA000 + 16'(i * 257));
            end
        end
        tests_run++;
        if (wr_overflow !== 1'b0 || wr_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: got overflow=%b full=%b, expected 0 0", wr_overflow, wr_full);
        end
    endtask

    task automatic test_overflow();
        int base_q, base_ack;
        do_reset(3);
        wr_delay = 1;
        wr_stall = 1'b1;
        base_q   = q_addr.size();
        base_ack = wr_ack_total;
        for (int i = 0; i < 16; i++) push_wr(28'h0020000 + 28'(2 * i), 16'(i));
        tests_run++;
        if (wr_full !== 1'b1 || wr_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_16: got full=%b overflow=%b, expected 1 0", wr_full, wr_overflow);
        end
        push_wr(28'h0030000, 16'hDEAD);
        tests_run++;
        if (wr_overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_17: got overflow=%b, expected 1", wr_overflow);
        end
        wr_stall = 1'b0;
        wait_acks(base_ack + 16, 500);
        repeat (10) tick();
        tests_run++;
        if (q_addr.size() - base_q !== 16 || q_addr[q_addr.size() - 1] !== 28'h002001E) begin
            tests_failed++;
            $display("FAIL ovf_drop: got %0d writes last=%h, expected 16 last=002001e", q_addr.size() - base_q, q_addr[q_addr.size() - 1]);
        end
        tests_run++;
        if (wr_overflow !== 1'b1 || wr_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_sticky: got overflow=%b full=%b, expected 1 0", wr_overflow, wr_full);
        end
        do_reset(3);
        tests_run++;
        if (wr_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_reset: got overflow=%b, expected 0", wr_overflow);
        end
    endtask

    task automatic test_raw_same_cycle();
        int base_ack, base_rd, n;
        do_reset(3);
        wr_delay  = 5;
        rd_delay  = 3;
        base_ack  = wr_ack_total;
        base_rd   = rd_issue_cnt;
        wr_addr   = 28'h0000100;
        wr_data   = 16'hBEEF;
        wr_strobe = 1'b1;
        rd_addr   = 28'h0000101;
        rd_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
        rd_strobe = 1'b0;
        tests_run++;
        if (rd_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_busy: got rd_busy=%b, expected 1", rd_busy);
        end
        n = 0;
        while (rd_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hBE) begin
            tests_failed++;
            $display("FAIL raw_data: got valid=%b data=%h, expected 1 be", rd_valid, rd_data);
        end
        tests_run++;
        if (rd_issue_cnt - base_rd !== 1 || rd_issue_wacks - base_ack !== 1) begin
            tests_failed++;
            $display("FAIL raw_order: got %0d reads after %0d write acks, expected 1 after 1", rd_issue_cnt - base_rd, rd_issue_wacks - base_ack);
        end
        tick();
        tests_run++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || rd_data !== 8'hBE) begin
            tests_failed++;
            $display("FAIL raw_pulse: got valid=%b busy=%b data=%h, expected 0 0 be", rd_valid, rd_busy, rd_data);
        end
    endtask

    task automatic test_read_ordering();
        int base_ack, base_iss, base_rd, n;
        do_reset(3);
        wr_delay = 2;
        rd_delay = 2;
        wr_stall = 1'b1;
        base_ack = wr_ack_total;
        base_iss = wr_issue_cnt;
        base_rd  = rd_issue_cnt;
        push_wr(28'h0000200, 16'h1234);
        push_wr(28'h0000202, 16'h5678);
        push_wr(28'h0000204, 16'h9ABC);
        rd_addr   = 28'h0000201;
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
        wr_stall  = 1'b0;
        for (int i = 0; i < 12; i++) push_wr(28'h0001000 + 28'(2 * i), 16'(i));
        n = 0;
        while ((rd_busy !== 1'b0 || rd_issue_cnt == base_rd) && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (rd_issue_wacks - base_ack !== 3 || rd_issue_wissue - base_iss !== 3) begin
            tests_failed++;
            $display("FAIL ord_issue: got read after %0d acks/%0d issues, expected 3/3", rd_issue_wacks - base_ack, rd_issue_wissue - base_iss);
        end
        tests_run++;
        if (rd_data !== 8'h12 || rd_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ord_data: got data=%h busy=%b, expected 12 0", rd_data, rd_busy);
        end
        wait_acks(base_ack + 15, 500);
        tests_run++;
        if (q_addr[base_iss + 3] !== 28'h0001000 || q_addr[base_iss + 14] !== 28'h0001016) begin
            tests_failed++;
            $display("FAIL ord_writes: got 4th=%h last=%h, expected 0001000 0001016", q_addr[base_iss + 3], q_addr[base_iss + 14]);
        end
    endtask

    task automatic test_busy_ignore();
        int base_ack, base_rd, n, bad;
        bit strobed;
        do_reset(3);
        wr_delay = 1;
        rd_delay = 6;
        base_ack = wr_ack_total;
        base_rd  = rd_issue_cnt;
        push_wr(28'h0000300, 16'hA55A);
        wait_acks(base_ack + 1, 50);
        rd_addr   = 28'h0000300;
        rd_strobe = 1'b1;
        tick();
        rd_addr = 28'h0000400;
        tick();
        rd_strobe = 1'b0;
        tests_run++;
        if (rd_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_flag: got rd_busy=%b, expected 1", rd_busy);
        end
        n = 0;
        bad = 0;
        strobed = 1'b0;
        while (rd_valid !== 1'b1 && n < 100) begin
            rd_strobe = 1'b0;
            if (rd_req !== rd_ack) begin
                if (rdaddr !== 28'h0000300) bad++;
                if (!strobed) begin
                    rd_strobe = 1'b1;
                    strobed   = 1'b1;
                end
            end
            tick();
            n++;
        end
        rd_strobe = 1'b0;
        tests_run++;
        if (bad !== 0 || rdaddr !== 28'h0000300 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_rdaddr: got %0d unstable cycles rdaddr=%h valid=%b, expected 0 0000300 1", bad, rdaddr, rd_valid);
        end
        tests_run++;
        if (rd_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL busy_data: got %h, expected 5a", rd_data);
        end
        repeat (20) tick();
        tests_run++;
        if (rd_issue_cnt - base_rd !== 1 || rd_busy !== 1'b0 || rdaddr !== 28'h0000300) begin
            tests_failed++;
            $display("FAIL busy_ignored: got %0d reads busy=%b rdaddr=%h, expected 1 0 0000300", rd_issue_cnt - base_rd, rd_busy, rdaddr);
        end
    endtask

    task automatic test_reset_mid_write();
        int base_ack, base_iss, valids;
        do_reset(3);
        wr_delay = 0;
        wr_stall = 1'b1;
        push_wr(28'h0000600, 16'h7777);
        tick();
        tests_run++;
        if (we_req === we_ack) begin
            tests_failed++;
            $display("FAIL mid_pre: got we_req=%b we_ack=%b, expected differing", we_req, we_ack);
        end
        do_reset(2);
        wr_stall = 1'b0;
        base_ack = wr_ack_total;
        base_iss = wr_issue_cnt;
        tests_run++;
        if (we_req !== we_ack || wr_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got we_req=%b we_ack=%b full=%b, expected equal and 0", we_req, we_ack, wr_full);
        end
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd_valid === 1'b1) valids++;
        end
        tests_run++;
        if (wr_issue_cnt != base_iss || wr_ack_total != base_ack || valids != 0 || we_req !== we_ack) begin
            tests_failed++;
            $display("FAIL mid_quiet: got issues=%0d acks=%0d valids=%0d, expected 0 0 0", wr_issue_cnt - base_iss, wr_ack_total - base_ack, valids);
        end
        push_wr(28'h0000500, 16'h1111);
        wait_acks(base_ack + 1, 50);
        tests_run++;
        if (wr_issue_cnt - base_iss !== 1 || q_addr[q_addr.size() - 1] !== 28'h0000500) begin
            tests_failed++;
            $display("FAIL mid_after: got %0d issues last=%h, expected 1 0000500", wr_issue_cnt - base_iss, q_addr[q_addr.size() - 1]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_raw_same_cycle();
        test_read_ordering();
        test_busy_ignore();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
